ahb_slave_mem: RTL and testbench

// - AHB-lite word-addressed memory responder; the target end of the DMAC master port
//   (MAddress/MWData/MWrite/MTrans/MBurst_Size).
// - Serves DMA source reads and destination writes with programmable wait states and an ERROR response.
// - Used as the system/peripheral memory in DMAC integration benches and in the SoC memory map.

---
 rtl/ahb_slave_mem.sv | 123 ++++++++++++
 tb/tb_ahb_slave_mem.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// AHB-lite word-addressed memory responder with programmable wait states.
// Optional ERROR response for misaligned/out-of-window accesses: define AHB_MEM_ERR_RESP_EN.
module ahb_slave_mem #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSel,
    input  logic [31:0] HAddr,
    input  logic        HWrite,
    input  logic [1:0]  HTrans,
    input  logic [3:0]  HBurst,
    input  logic [31:0] HWData,
    input  logic        HReadyIn,
    output logic [31:0] HRData,
    output logic        HReadyOut,
    output logic [1:0]  HResp
);

    // state | meaning
    // IDLE  | no phase, or completion cycle of an accepted transfer (phase_q=1)
    // WAIT  | data phase extended, HReadyOut low
    // ERR1  | first ERROR cycle, HReadyOut low
    // ERR2  | second ERROR cycle, HReadyOut high
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           phase_q, phase_d;
    logic           write_q;
    logic [AW-1:0]  idx_q, idx_d;
    logic [31:0]    rdata_q;
    logic [31:0]    offset;
    logic           accept, err_addr, load, complete;
    logic           unused;
    logic [31:0]    mem [0:DEPTH-1];

    assign offset = HAddr - ADDR_BASE;
    assign idx_d  = offset[AW+1:2];
    assign accept = HSel & HTrans[1] & HReadyIn;
    assign unused = ^{offset[31:AW+2], offset[1:0], HBurst, HTrans[0]};

`ifdef AHB_MEM_ERR_RESP_EN
    // 33-bit limit so a window ending at the top of the address space does not wrap
    localparam logic [32:0] LIMIT = {1'b0, ADDR_BASE} + 33'(DEPTH) * 33'd4;
    assign err_addr = (HAddr[1:0] != 2'b00) || (HAddr < ADDR_BASE) || ({1'b0, HAddr} >= LIMIT);
    assign HResp    = (state_q == S_ERR1 || state_q == S_ERR2) ? 2'b01 : 2'b00;
`else
    assign err_addr = 1'b0;
    assign HResp    = 2'b00;
`endif

    assign complete  = phase_q && (state_q == S_IDLE);
    assign HReadyOut = (state_q == S_IDLE) || (state_q == S_ERR2);
    // Combinational read path keeps a read accepted on a write's commit edge coherent
    assign HRData    = (complete && !write_q) ? mem[idx_q] : rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE, S_ERR2: begin
                state_d = S_IDLE;
                phase_d = 1'b0;
                if (accept) begin
                    load = 1'b1;
                    if (err_addr) begin
                        state_d = S_ERR1;
                    end else begin
                        phase_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d = S_WAIT;
                            cnt_d   = WS - 4'd1;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
`ifdef AHB_MEM_ERR_RESP_EN
            S_ERR1: state_d = S_ERR2;
`endif
            default: begin
                state_d = S_IDLE;
                phase_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            phase_q <= 1'b0;
            write_q <= 1'b0;
            idx_q   <= '0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            if (load) begin
                write_q <= HWrite;
                idx_q   <= idx_d;
            end
            if (complete && !write_q) rdata_q <= mem[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && complete && write_q) mem[idx_q] <= HWData;
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench for ahb_slave_mem: three instances (0, 2 and 3 wait states),
// one selected at a time; expectations adapt to AHB_MEM_ERR_RESP_EN.
module tb_ahb_slave_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        HSel = 1'b0;
    logic [31:0] HAddr = 32'h0;
    logic [31:0] HWData = 32'h0;
    logic        HWrite = 1'b0;
    logic [1:0]  HTrans = 2'b00;
    logic [3:0]  HBurst = 4'h0;
    int          tgt = 0;

    logic [2:0]  sel;
    logic [2:0]  hready;
    logic [1:0]  hresp [3];
    logic [31:0] hrdata [3];

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
        int          waits;
        logic [1:0]  resp;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] last_rd [3];
    bit          active;
    int          wcnt;
    exp_t        e_mon;

    localparam logic [1:0] NS = 2'b10, SQ = 2'b11;

    always #5 clk = ~clk;

    assign sel[0] = HSel && (tgt == 0);
    assign sel[1] = HSel && (tgt == 1);
    assign sel[2] = HSel && (tgt == 2);

    ahb_slave_mem #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .HSel(sel[0]), .HAddr(HAddr), .HWrite(HWrite), .HTrans(HTrans),
        .HBurst(HBurst), .HWData(HWData), .HReadyIn(hready[0]), .HRData(hrdata[0]),
        .HReadyOut(hready[0]), .HResp(hresp[0]));

    ahb_slave_mem #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst), .HSel(sel[1]), .HAddr(HAddr), .HWrite(HWrite), .HTrans(HTrans),
        .HBurst(HBurst), .HWData(HWData), .HReadyIn(hready[1]), .HRData(hrdata[1]),
        .HReadyOut(hready[1]), .HResp(hresp[1]));

    ahb_slave_mem #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .HSel(sel[2]), .HAddr(HAddr), .HWrite(HWrite), .HTrans(HTrans),
        .HBurst(HBurst), .HWData(HWData), .HReadyIn(hready[2]), .HRData(hrdata[2]),
        .HReadyOut(hready[2]), .HResp(hresp[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s (target %0d, t=%0t): got %h, expected %h", name, tgt, $time, act, req);
        end
    endtask

    // Waits for the rising edge at which the selected slave's bus HREADY is high
    task automatic wait_ready();
        logic rdy;
        int   n;
        n = 0;
        forever begin
            @(negedge clk);
            rdy = hready[tgt];
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 50) begin
                checks++;
                fails++;
                $display("FAIL accept_timeout (target %0d): HReadyOut stuck low", tgt);
                break;
            end
        end
        #1;
    endtask

    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] trans, input int waits, input logic [1:0] resp);
        exp_t e;
        e.is_read = !wr;
        e.data    = data;
        e.waits   = waits;
        e.resp    = resp;
        exp_q.push_back(e);
        HSel   = 1'b1;
        HAddr  = addr;
        HWrite = wr;
        HTrans = trans;
        wait_ready();
        HSel   = 1'b0;
        HTrans = 2'b00;
        if (wr) HWData = data;
    endtask

    task automatic busy(input logic [31:0] addr);
        HSel   = 1'b1;
        HAddr  = addr;
        HTrans = 2'b01;
        wait_ready();
        HSel   = 1'b0;
        HTrans = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: checks every cycle of the selected slave against the queue head
    initial begin
        active = 1'b0;
        wcnt   = 0;
        foreach (last_rd[i]) last_rd[i] = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (active) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL scoreboard (target %0d): data phase with empty queue", tgt);
                        active = 1'b0;
                    end else if (hready[tgt] == 1'b0) begin
                        wcnt++;
                        check("wait_resp", 32'(hresp[tgt]), 32'(exp_q[0].resp));
                    end else begin
                        e_mon = exp_q.pop_front();
                        check("wait_count", wcnt, e_mon.waits);
                        check("resp", 32'(hresp[tgt]), 32'(e_mon.resp));
                        if (e_mon.is_read && e_mon.resp == 2'b00) begin
                            check("rdata", hrdata[tgt], e_mon.data);
                            last_rd[tgt] = e_mon.data;
                        end
                        active = 1'b0;
                    end
                end else begin
                    check("idle_ready", 32'(hready[tgt]), 32'd1);
                    check("idle_resp", 32'(hresp[tgt]), 32'd0);
                    check("idle_rdata_hold", hrdata[tgt], last_rd[tgt]);
                end
            end
            @(posedge clk);
            if (rst) begin
                if (active && exp_q.size() > 0) void'(exp_q.pop_front());
                active = 1'b0;
                foreach (last_rd[i]) last_rd[i] = 32'h0;
            end else if (HSel && HTrans[1] && hready[tgt]) begin
                active = 1'b1;
                wcnt   = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Zero wait states: back-to-back write/read, last word, window aliasing or ERROR
        tgt = 0;
        xfer(1, 32'h100, 32'hDEADBEEF, NS, 0, 2'b00);
        xfer(0, 32'h100, 32'hDEADBEEF, NS, 0, 2'b00);
        xfer(1, 32'h000, 32'h0BADF00D, NS, 0, 2'b00);
        xfer(1, 32'hFFC, 32'h0000FFFC, NS, 0, 2'b00);
        xfer(0, 32'hFFC, 32'h0000FFFC, NS, 0, 2'b00);
        xfer(0, 32'h000, 32'h0BADF00D, NS, 0, 2'b00);
`ifdef AHB_MEM_ERR_RESP_EN
        xfer(1, 32'h1000, 32'h12345678, NS, 1, 2'b01);
        xfer(0, 32'h000, 32'h0BADF00D, NS, 0, 2'b00);
        xfer(0, 32'h002, 32'h00000000, NS, 1, 2'b01);
        xfer(0, 32'h100, 32'hDEADBEEF, NS, 0, 2'b00);
`else
        xfer(1, 32'h1000, 32'hA5A5A5A5, NS, 0, 2'b00);
        xfer(0, 32'h000, 32'hA5A5A5A5, NS, 0, 2'b00);
        xfer(0, 32'h1100, 32'hDEADBEEF, NS, 0, 2'b00);
`endif
        idle(3);

        // Two wait states: single read, then 4-beat bursts with a BUSY after beat 2
        tgt = 1;
        xfer(1, 32'h004, 32'hCAFE0004, NS, 2, 2'b00);
        xfer(0, 32'h004, 32'hCAFE0004, NS, 2, 2'b00);
        HBurst = 4'h3;
        xfer(1, 32'h010, 32'h11110010, NS, 2, 2'b00);
        xfer(1, 32'h014, 32'h22220014, SQ, 2, 2'b00);
        busy(32'h018);
        xfer(1, 32'h018, 32'h33330018, SQ, 2, 2'b00);
        xfer(1, 32'h01C, 32'h4444001C, SQ, 2, 2'b00);
        xfer(0, 32'h010, 32'h11110010, NS, 2, 2'b00);
        xfer(0, 32'h014, 32'h22220014, SQ, 2, 2'b00);
        busy(32'h018);
        xfer(0, 32'h018, 32'h33330018, SQ, 2, 2'b00);
        xfer(0, 32'h01C, 32'h4444001C, SQ, 2, 2'b00);
        HBurst = 4'h0;
        idle(5);

        // Three wait states: reset during the second wait cycle drops the write
        tgt = 2;
        xfer(1, 32'h020, 32'h00000011, NS, 3, 2'b00);
        idle(5);
        xfer(1, 32'h020, 32'h00000055, NS, 3, 2'b00);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        xfer(0, 32'h020, 32'h00000011, NS, 3, 2'b00);
        idle(6);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
